alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single calculator ALU between NumReq requesters, e.g. the keypad controller and a
//  memory/recall unit. Round-robin arbitration, one transaction outstanding at a time.
//  Operands and op are latched on accept; the result is buffered and returned to the winner.
//  Sits between the requesters' ALU ports and the ALU's in/out valid-ready handshakes.
// PARAMETERS
//  NumReq  2  number of requesters (>=2); IdW = $clog2(NumReq)
// PORTS
//  clk_i            in   1               clock; all state changes on posedge
//  rst_i            in   1               synchronous, active-high reset
//  req_left_i       in   NumReq x num_t  per-requester left operand
//  req_right_i      in   NumReq x num_t  per-requester right operand
//  req_op_i         in   NumReq x op_t   per-requester operation
//  req_in_valid_i   in   NumReq          request valid; held until accepted
//  req_in_ready_o   out  NumReq          one-hot accept strobe
//  req_result_o     out  num_t           buffered result, shared by all requesters
//  req_out_valid_o  out  NumReq          one-hot result valid, granted requester only
//  req_out_ready_i  in   NumReq          requester consumes result
//  alu_left_o       out  num_t           latched left operand
//  alu_right_o      out  num_t           latched right operand
//  alu_op_o         out  op_t            latched op
//  alu_in_valid_o   out  1               operands valid to ALU
//  alu_in_ready_i   in   1               ALU accepts operands
//  alu_result_i     in   num_t           ALU result
//  alu_out_valid_i  in   1               ALU result valid
//  alu_out_ready_o  out  1               arbiter accepts result
// BEHAVIOUR
//  - FSM states: S_IDLE -> S_ISSUE -> S_COLLECT -> S_RETURN -> S_IDLE.
//  - S_IDLE: winner = first i with req_in_valid_i[i], searching upward from rr_ptr with wrap.
//    * req_in_ready_o[winner] = 1, combinational, same cycle. No valid bit set: all ready bits 0.
//    * On that edge: latch left, right, op and grant_id; go to S_ISSUE.
//  - S_ISSUE: alu_in_valid_o = 1. When alu_in_ready_i = 1: go to S_COLLECT.
//  - S_COLLECT: alu_out_ready_o = 1. When alu_out_valid_i = 1: capture alu_result_i; go to S_RETURN.
//  - S_RETURN: req_out_valid_o[grant_id] = 1; req_result_o = captured result.
//    * When req_out_ready_i[grant_id] = 1: rr_ptr <= (grant_id+1) mod NumReq; go to S_IDLE.
//  - Handshake outputs depend only on state (registered):
//    * alu_in_valid_o in S_ISSUE only; alu_out_ready_o in S_COLLECT only.
//    * req_in_ready_o is nonzero only in S_IDLE.
//  - Latency: accept -> ALU issue 1 cycle. Best case 4 cycles accept-to-return-complete
//    (zero-wait ALU and requester). Back-to-back accept possible the cycle after return completes.
//  - Busy: requests raised in other states wait; req_in_ready_o stays 0. No request is dropped.
//  - Fairness: a requester just served gets lowest priority next round. Two requesters
//    continuously valid alternate 0,1,0,1.
//  - Wrap: rr_ptr at NumReq-1 wraps to 0; the search wraps past NumReq-1.
//  - Simultaneous: in S_RETURN, another requester's valid is ignored until S_IDLE;
//    it is accepted the cycle after return completes.
//  - Non-winning ready bits are 0. Winner's ready bits in the wrong state are ignored.
//  - Reset values: state S_IDLE, rr_ptr 0, grant_id 0, all valid/ready outputs 0,
//    latched operands/op/result 0.
//  - Reset mid-transaction abandons it and returns no result. The ALU shares rst_i.
// CONFIGURATION
//  - CALC_ALU_ARB_STATS_EN defined adds two outputs:
//    * txn_count_o [31:0]: increments on each completed S_RETURN handshake.
//    * busy_cycles_o [31:0]: increments every cycle state != S_IDLE.
//    * Both saturate at all-ones and reset to 0.
//  - Undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Single req0 (3 OP_ADD 4), zero-wait ALU/requester -> ready0 pulses once, result 7 on
//    req_out_valid_o=2'b01, back in S_IDLE 4 cycles after accept.
//  - req0 and req1 valid together from reset -> req0 served first, then req1;
//    with both held continuously the grant order is 0,1,0,1.
//  - ALU stalls alu_in_ready_i low 5 cycles -> alu_in_valid_o held high and alu_left_o /
//    alu_right_o / alu_op_o stable throughout; req1 raised meanwhile sees ready 0.
//  - Requester holds req_out_ready_i low 3 cycles in S_RETURN -> req_out_valid_o and
//    req_result_o stable, no new accept until it rises.
//  - rst_i asserted during S_COLLECT -> next cycle all valid/ready outputs 0, state S_IDLE;
//    a pending req1 is then accepted normally (rr_ptr 0 search order).
//  - With STATS_EN, 3 transactions of 4 busy cycles each -> txn_count_o=3, busy_cycles_o=12.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Valid/ready bundle between the requesters, alu_arbiter and the shared calculator ALU.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface alu_arbiter_if #(
    parameter int NumReq = 2,
    parameter int NumW   = 16,
    parameter int OpW    = 2
);
    logic [NumReq-1:0][NumW-1:0] req_left_i;
    logic [NumReq-1:0][NumW-1:0] req_right_i;
    logic [NumReq-1:0][OpW-1:0]  req_op_i;
    logic [NumReq-1:0]           req_in_valid_i;
    logic [NumReq-1:0]           req_in_ready_o;
    logic [NumW-1:0]             req_result_o;
    logic [NumReq-1:0]           req_out_valid_o;
    logic [NumReq-1:0]           req_out_ready_i;
    logic [NumW-1:0]             alu_left_o;
    logic [NumW-1:0]             alu_right_o;
    logic [OpW-1:0]              alu_op_o;
    logic                        alu_in_valid_o;
    logic                        alu_in_ready_i;
    logic [NumW-1:0]             alu_result_i;
    logic                        alu_out_valid_i;
    logic                        alu_out_ready_o;

    modport slave (
        input  req_left_i, req_right_i, req_op_i, req_in_valid_i, req_out_ready_i,
        input  alu_in_ready_i, alu_result_i, alu_out_valid_i,
        output req_in_ready_o, req_result_o, req_out_valid_o,
        output alu_left_o, alu_right_o, alu_op_o, alu_in_valid_o, alu_out_ready_o
    );

    modport master (
        output req_left_i, req_right_i, req_op_i, req_in_valid_i, req_out_ready_i,
        output alu_in_ready_i, alu_result_i, alu_out_valid_i,
        input  req_in_ready_o, req_result_o, req_out_valid_o,
        input  alu_left_o, alu_right_o, alu_op_o, alu_in_valid_o, alu_out_ready_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one calculator ALU between NumReq requesters, one transaction at a time.
// Defining CALC_ALU_ARB_STATS_EN adds saturating txn_count_o / busy_cycles_o counters.
module alu_arbiter #(
    parameter int NumReq = 2,
    parameter int NumW   = 16,
    parameter int OpW    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_arbiter_if.slave  bus
`ifdef CALC_ALU_ARB_STATS_EN
    ,
    output logic [31:0]   txn_count_o,
    output logic [31:0]   busy_cycles_o
`endif
);
    localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT,
        S_RETURN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IdW-1:0]   rr_ptr;
    logic [IdW-1:0]   grant_id;
    logic [NumW-1:0]  left_q;
    logic [NumW-1:0]  right_q;
    logic [OpW-1:0]   op_q;
    logic [NumW-1:0]  result_q;
    logic             win_found;
    logic [IdW-1:0]   win_id;
    logic [IdW-1:0]   cand;
    logic             ret_done;

    // Search upward from rr_ptr with wrap so the requester just served is considered last.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdW'((int'(rr_ptr) + k) % NumReq);
            if (!win_found && bus.req_in_valid_i[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign ret_done = (state == S_RETURN) && bus.req_out_ready_i[grant_id];

    always_comb begin
        state_next          = state;
        bus.req_in_ready_o  = '0;
        bus.req_out_valid_o = '0;
        bus.alu_in_valid_o  = 1'b0;
        bus.alu_out_ready_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (win_found) begin
                    bus.req_in_ready_o[win_id] = 1'b1;
                    state_next                 = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.alu_in_valid_o = 1'b1;
                if (bus.alu_in_ready_i) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                bus.alu_out_ready_o = 1'b1;
                if (bus.alu_out_valid_i) begin
                    state_next = S_RETURN;
                end
            end
            S_RETURN: begin
                bus.req_out_valid_o[grant_id] = 1'b1;
                if (ret_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.req_result_o = result_q;
    assign bus.alu_left_o   = left_q;
    assign bus.alu_right_o  = right_q;
    assign bus.alu_op_o     = op_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && win_found) begin
                left_q   <= bus.req_left_i[win_id];
                right_q  <= bus.req_right_i[win_id];
                op_q     <= bus.req_op_i[win_id];
                grant_id <= win_id;
            end
            if (state == S_COLLECT && bus.alu_out_valid_i) begin
                result_q <= bus.alu_result_i;
            end
            if (ret_done) begin
                rr_ptr <= (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + IdW'(1);
            end
        end
    end

`ifdef CALC_ALU_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            txn_count_o   <= '0;
            busy_cycles_o <= '0;
        end else begin
            if (ret_done && txn_count_o != '1) begin
                txn_count_o <= txn_count_o + 32'd1;
            end
            if (state != S_IDLE && busy_cycles_o != '1) begin
                busy_cycles_o <= busy_cycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: requester/ALU agents plus a transaction-level round-robin model.
module tb_alu_arbiter;
    localparam int NumReq = 2;
    localparam int NumW   = 16;
    localparam int OpW    = 2;
    localparam logic [OpW-1:0] OpAdd = 2'd0;
    localparam logic [OpW-1:0] OpSub = 2'd1;
    localparam logic [OpW-1:0] OpAnd = 2'd2;

    logic clk_i;
    logic rst_i;

    alu_arbiter_if #(.NumReq(NumReq), .NumW(NumW), .OpW(OpW)) bus ();

`ifdef CALC_ALU_ARB_STATS_EN
    logic [31:0] txn_count;
    logic [31:0] busy_cycles;
`endif

    alu_arbiter #(.NumReq(NumReq), .NumW(NumW), .OpW(OpW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus           (bus)
`ifdef CALC_ALU_ARB_STATS_EN
        ,
        .txn_count_o   (txn_count),
        .busy_cycles_o (busy_cycles)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    logic            req_has [NumReq];
    logic [NumW-1:0] req_l   [NumReq];
    logic [NumW-1:0] req_r   [NumReq];
    logic [OpW-1:0]  req_o   [NumReq];

    bit              alu_pend;
    bit              alu_valid;
    int              alu_wait;
    logic [NumW-1:0] alu_res;

    // Model: one outstanding transaction, phase 0 = awaiting ALU issue, 1 = awaiting result, 2 = returning.
    bit              m_busy;
    int              m_stage;
    int              m_winner;
    int              m_ptr;
    logic [NumW-1:0] m_l, m_r, m_result;
    logic [OpW-1:0]  m_op;
    int              stat_txn, stat_busy;

    int env_accepts, env_returns, abandoned;
    int grant_log[$];
    int cyc, acc_cycle, ret_cycle;
    logic [NumW-1:0] last_ret_result;
    int last_ret_id;

    int p_req, p_alu_in, alu_max_wait, p_ret;
    bit reset_want, hold_rst;

    function automatic logic [NumW-1:0] calc(input logic [OpW-1:0] op,
                                             input logic [NumW-1:0] a, input logic [NumW-1:0] b);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NumReq; i++) begin
            if (!req_has[i] && int'($urandom_range(99, 0)) < p_req) begin
                req_has[i] = 1'b1;
                req_l[i]   = NumW'($urandom);
                req_r[i]   = NumW'($urandom);
                req_o[i]   = OpW'($urandom);
            end
            bus.req_in_valid_i[i]  = req_has[i];
            bus.req_left_i[i]      = req_l[i];
            bus.req_right_i[i]     = req_r[i];
            bus.req_op_i[i]        = req_o[i];
            bus.req_out_ready_i[i] = int'($urandom_range(99, 0)) < p_ret;
        end
        bus.alu_in_ready_i = int'($urandom_range(99, 0)) < p_alu_in;
        if (alu_pend && !alu_valid) begin
            if (alu_wait == 0) alu_valid = 1'b1;
            else alu_wait--;
        end
        bus.alu_out_valid_i = alu_valid;
        bus.alu_result_i    = alu_valid ? alu_res : NumW'($urandom);
        if (reset_want && m_busy && m_stage == 1) begin
            rst_i      = 1'b1;
            reset_want = 1'b0;
        end else begin
            rst_i = hold_rst;
        end
    endtask

    task automatic runCycle();
        logic [NumReq-1:0] exp_ready, exp_ov, env_acc, env_ret;
        bit found, was_rst, iss, col, ret, env_iss, env_col;
        int win, idx;
        logic [NumW-1:0] seen_l, seen_r;
        logic [OpW-1:0]  seen_op;

        @(negedge clk_i);
        cyc++;
        was_rst   = rst_i;
        found     = 1'b0;
        win       = 0;
        exp_ready = '0;
        if (!m_busy) begin
            for (int k = 0; k < NumReq; k++) begin
                idx = (m_ptr + k) % NumReq;
                if (!found && req_has[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) exp_ready[win] = 1'b1;
        end
        exp_ov = '0;
        if (m_busy && m_stage == 2) exp_ov[m_winner] = 1'b1;

        checkOutput("req_in_ready", 32'(bus.req_in_ready_o), 32'(exp_ready));
        checkOutput("alu_in_valid", 32'(bus.alu_in_valid_o), 32'(m_busy && m_stage == 0));
        checkOutput("alu_out_ready", 32'(bus.alu_out_ready_o), 32'(m_busy && m_stage == 1));
        checkOutput("req_out_valid", 32'(bus.req_out_valid_o), 32'(exp_ov));
        if (m_busy && m_stage == 0) begin
            checkOutput("alu_left", 32'(bus.alu_left_o), 32'(m_l));
            checkOutput("alu_right", 32'(bus.alu_right_o), 32'(m_r));
            checkOutput("alu_op", 32'(bus.alu_op_o), 32'(m_op));
        end
        if (m_busy && m_stage == 2) begin
            checkOutput("req_result", 32'(bus.req_result_o), 32'(m_result));
        end

        iss     = m_busy && m_stage == 0 && bus.alu_in_ready_i;
        col     = m_busy && m_stage == 1 && bus.alu_out_valid_i;
        ret     = m_busy && m_stage == 2 && bus.req_out_ready_i[m_winner];
        env_acc = bus.req_in_valid_i & bus.req_in_ready_o;
        env_ret = bus.req_out_valid_o & bus.req_out_ready_i;
        env_iss = bus.alu_in_valid_o && bus.alu_in_ready_i;
        env_col = bus.alu_out_valid_i && bus.alu_out_ready_o;
        seen_l  = bus.alu_left_o;
        seen_r  = bus.alu_right_o;
        seen_op = bus.alu_op_o;

        @(posedge clk_i);
        #1;
        if (was_rst) begin
            if (m_busy) abandoned++;
            m_busy    = 1'b0;
            m_stage   = 0;
            m_ptr     = 0;
            stat_txn  = 0;
            stat_busy = 0;
            alu_pend  = 1'b0;
            alu_valid = 1'b0;
        end else begin
            if (m_busy) stat_busy++;
            if (found) begin
                m_busy   = 1'b1;
                m_stage  = 0;
                m_winner = win;
                m_l      = req_l[win];
                m_r      = req_r[win];
                m_op     = req_o[win];
                m_result = calc(req_o[win], req_l[win], req_r[win]);
            end else if (iss) begin
                m_stage = 1;
            end else if (col) begin
                m_stage = 2;
            end else if (ret) begin
                m_busy = 1'b0;
                m_ptr  = (m_winner + 1) % NumReq;
                stat_txn++;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (env_acc[i]) begin
                    req_has[i] = 1'b0;
                    env_accepts++;
                    grant_log.push_back(i);
                    acc_cycle = cyc;
                end
                if (env_ret[i]) begin
                    env_returns++;
                    last_ret_id     = i;
                    last_ret_result = bus.req_result_o;
                    ret_cycle       = cyc;
                end
            end
            if (env_iss) begin
                alu_pend = 1'b1;
                alu_wait = int'($urandom_range(alu_max_wait, 0));
                alu_res  = calc(seen_op, seen_l, seen_r);
            end
            if (env_col) begin
                alu_pend  = 1'b0;
                alu_valid = 1'b0;
            end
        end
        applyStimulus();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pending;
        for (int i = 0; i < NumReq; i++) begin
            req_has[i] = 1'b0;
            req_l[i]   = '0;
            req_r[i]   = '0;
            req_o[i]   = '0;
        end
        alu_pend = 1'b0; alu_valid = 1'b0; alu_wait = 0; alu_res = '0;
        m_busy = 1'b0; m_stage = 0; m_winner = 0; m_ptr = 0;
        m_l = '0; m_r = '0; m_op = '0; m_result = '0;
        stat_txn = 0; stat_busy = 0; env_accepts = 0; env_returns = 0; abandoned = 0;
        cyc = 0; acc_cycle = 0; ret_cycle = 0; last_ret_result = '0; last_ret_id = -1;
        p_req = 0; p_alu_in = 100; alu_max_wait = 0; p_ret = 100;
        reset_want = 1'b0;
        hold_rst   = 1'b1;
        rst_i      = 1'b1;
        applyStimulus();

        repeat (3) runCycle();
        hold_rst = 1'b0;
        rst_i    = 1'b0;
        checkOutput("reset_result", 32'(bus.req_result_o), 32'd0);
        checkOutput("reset_alu_left", 32'(bus.alu_left_o), 32'd0);

        // Single req0: 3 + 4 with zero-wait ALU and requester.
        req_has[0] = 1'b1; req_l[0] = 16'd3; req_r[0] = 16'd4; req_o[0] = OpAdd;
        applyStimulus();
        repeat (6) runCycle();
        checkOutput("add_result", 32'(last_ret_result), 32'd7);
        checkOutput("add_ret_id", 32'(last_ret_id), 32'd0);
        checkOutput("add_latency", 32'(ret_cycle - acc_cycle), 32'd3);
        checkOutput("add_accepts", 32'(env_accepts), 32'd1);

        // Both requesters held valid: grants must alternate, starting with req1 after req0 was served.
        grant_log.delete();
        p_req = 100;
        repeat (40) runCycle();
        checkOutput("alt_enough_grants", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < grant_log.size(); k++) begin
            checkOutput("alt_order", 32'(grant_log[k]), 32'((1 + k) % NumReq));
        end

        // Reset while waiting on the ALU result, then pending requests resume from rr_ptr 0.
        p_req = 60; p_alu_in = 100; alu_max_wait = 3; p_ret = 100;
        reset_want = 1'b1;
        repeat (40) runCycle();
        checkOutput("reset_abandoned", 32'(abandoned), 32'd1);

        // Random traffic with ALU stalls and slow requesters, occasionally reset mid-transaction.
        p_req = 35; p_alu_in = 45; alu_max_wait = 4; p_ret = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) reset_want = 1'b1;
            runCycle();
        end
        reset_want = 1'b0;

        // Drain everything outstanding.
        p_req = 0; p_alu_in = 100; alu_max_wait = 0; p_ret = 100;
        pending = 1;
        for (int n = 0; n < 60 && pending != 0; n++) begin
            runCycle();
            pending = m_busy ? 1 : 0;
            for (int i = 0; i < NumReq; i++) if (req_has[i]) pending = 1;
        end
        checkOutput("drain_done", 32'(pending), 32'd0);
        checkOutput("no_drop", 32'(env_returns + abandoned), 32'(env_accepts));

`ifdef CALC_ALU_ARB_STATS_EN
        checkOutput("txn_count", txn_count, 32'(stat_txn));
        checkOutput("busy_cycles", busy_cycles, 32'(stat_busy));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
